// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch control path.
package fetch_pkg;

  localparam int          ADDR_W        = 16;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    RUN      = 3'd1,
    STALL    = 3'd2,
    REDIRECT = 3'd3,
    HALTED   = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic pc_enable;
    logic branch_selector;
    logic flush;
    logic if_id_nop;
  } fetch_ctrl_t;

  // Control word held while in BOOT, which is also the reset state.
  localparam fetch_ctrl_t CTRL_RESET = '{pc_enable: 1'b0, branch_selector: 1'b0,
                                         flush: 1'b0, if_id_nop: 1'b1};

  // Maps a state onto the control word the fetch datapath sees in that state.
  function automatic fetch_ctrl_t decode_ctrl(input fetch_state_e s);
    fetch_ctrl_t c;
    c = '0;
    case (s)
      BOOT:     c.if_id_nop = 1'b1;
      RUN:      c.pc_enable = 1'b1;
      STALL:    c = '0;
      REDIRECT: begin
        c.pc_enable       = 1'b1;
        c.branch_selector = 1'b1;
        c.flush           = 1'b1;
      end
      HALTED:   c.if_id_nop = 1'b1;
      default:  c = CTRL_RESET;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Request and control signals exchanged between the pipeline and the fetch controller.
interface fetch_controller_if;
  import fetch_pkg::*;

  logic              load_use_hazard;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              halt;
  logic              resume;

  logic              pc_enable;
  logic              branch_selector;
  logic [ADDR_W-1:0] jmp_result;
  logic              flush;
  logic              if_id_nop;
  logic [2:0]        fetch_state;
  logic [15:0]       stall_count;

  // Pipeline side: raises requests, consumes fetch controls.
  modport master (
    output load_use_hazard, branch_taken, branch_target, halt, resume,
    input  pc_enable, branch_selector, jmp_result, flush, if_id_nop,
           fetch_state, stall_count
  );

  // Controller side.
  modport slave (
    input  load_use_hazard, branch_taken, branch_target, halt, resume,
    output pc_enable, branch_selector, jmp_result, flush, if_id_nop,
           fetch_state, stall_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: advance only when enabled and not already saturated.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: boot hold-off, stalls, branch redirects and HALT/resume.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int BOOT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  fetch_controller_if.slave bus
);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  fetch_state_e      state_q, state_d;
  logic [7:0]        boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0] jmp_result_q, jmp_result_d;
  fetch_ctrl_t       ctrl_q, ctrl_d;
  logic              stall_en;
  logic [15:0]       stall_count;

  // Next-state selection; controls are decoded from the next state so they are registered alongside it.
  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    jmp_result_d = jmp_result_q;
    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = RUN;
        end
      end
      REDIRECT: begin
        state_d = RUN;
      end
      RUN, STALL, HALTED: begin
        if (bus.branch_taken) begin
          jmp_result_d = bus.branch_target;
          state_d      = REDIRECT;
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.load_use_hazard && (state_q != HALTED)) begin
          state_d = STALL;
        end else if (bus.resume && (state_q == HALTED)) begin
          state_d = RUN;
        end else if (state_q == STALL) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    ctrl_d = decode_ctrl(state_d);
  end

  // State, boot counter, redirect target and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      boot_cnt_q   <= 8'd0;
      jmp_result_q <= '0;
      ctrl_q       <= CTRL_RESET;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      jmp_result_q <= jmp_result_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign stall_en = (state_q == STALL) || (state_q == HALTED);

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (stall_en),
    .count (stall_count)
  );

  assign bus.pc_enable       = ctrl_q.pc_enable;
  assign bus.branch_selector = ctrl_q.branch_selector;
  assign bus.flush           = ctrl_q.flush;
  assign bus.if_id_nop       = ctrl_q.if_id_nop;
  assign bus.jmp_result      = jmp_result_q;
  assign bus.fetch_state     = state_q;
  assign bus.stall_count     = stall_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: vector table plus hand-written multi-cycle sequences.
module tb_fetch_controller;
  import fetch_pkg::*;

  typedef struct {
    logic         bt;
    logic [15:0]  tgt;
    logic         halt;
    logic         luh;
    logic         res;
    fetch_state_e st;
    logic         pe;
    logic         bs;
    logic         fl;
    logic         nop;
    logic [15:0]  jmp;
    logic [15:0]  sc;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  fetch_controller_if bus();

  fetch_controller #(.BOOT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic bt, input logic [15:0] tgt, input logic halt,
                              input logic luh, input logic res, input fetch_state_e st,
                              input logic pe, input logic bs, input logic fl, input logic nop,
                              input logic [15:0] jmp, input logic [15:0] sc);
    vec_t v;
    v.bt = bt; v.tgt = tgt; v.halt = halt; v.luh = luh; v.res = res;
    v.st = st; v.pe = pe; v.bs = bs; v.fl = fl; v.nop = nop; v.jmp = jmp; v.sc = sc;
    return v;
  endfunction

  task automatic applyStimulus(input logic bt, input logic [15:0] tgt, input logic halt,
                               input logic luh, input logic res);
    bus.branch_taken    = bt;
    bus.branch_target   = tgt;
    bus.halt            = halt;
    bus.load_use_hazard = luh;
    bus.resume          = res;
  endtask

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input fetch_state_e st, input logic pe,
                             input logic bs, input logic fl, input logic nop,
                             input logic [15:0] jmp, input logic [15:0] sc);
    checkVal({tag, ".state"}, 16'(bus.fetch_state), 16'(st));
    checkVal({tag, ".pc_enable"}, 16'(bus.pc_enable), 16'(pe));
    checkVal({tag, ".branch_selector"}, 16'(bus.branch_selector), 16'(bs));
    checkVal({tag, ".flush"}, 16'(bus.flush), 16'(fl));
    checkVal({tag, ".if_id_nop"}, 16'(bus.if_id_nop), 16'(nop));
    checkVal({tag, ".jmp_result"}, bus.jmp_result, jmp);
    checkVal({tag, ".stall_count"}, bus.stall_count, sc);
  endtask

  // One cycle: drive at the falling edge, sample just after the rising edge.
  task automatic stepCycle(input logic bt, input logic [15:0] tgt, input logic halt,
                           input logic luh, input logic res);
    @(negedge clk);
    applyStimulus(bt, tgt, halt, luh, res);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[17];
    checks = 0;
    passes = 0;

    // Starting from RUN right after boot with stall_count = 0.
    vecs[0]  = mk(0, 16'h0000, 0, 0, 0, RUN,      1, 0, 0, 0, 16'h0000, 16'd0);
    vecs[1]  = mk(1, 16'h0040, 0, 0, 0, REDIRECT, 1, 1, 1, 0, 16'h0040, 16'd0);
    vecs[2]  = mk(0, 16'h0000, 0, 0, 0, RUN,      1, 0, 0, 0, 16'h0040, 16'd0);
    vecs[3]  = mk(0, 16'h0000, 0, 1, 0, STALL,    0, 0, 0, 0, 16'h0040, 16'd0);
    vecs[4]  = mk(0, 16'h0000, 0, 1, 0, STALL,    0, 0, 0, 0, 16'h0040, 16'd1);
    vecs[5]  = mk(0, 16'h0000, 0, 1, 0, STALL,    0, 0, 0, 0, 16'h0040, 16'd2);
    vecs[6]  = mk(0, 16'h0000, 0, 0, 0, RUN,      1, 0, 0, 0, 16'h0040, 16'd3);
    vecs[7]  = mk(0, 16'h0000, 0, 1, 0, STALL,    0, 0, 0, 0, 16'h0040, 16'd3);
    vecs[8]  = mk(1, 16'h0080, 0, 1, 0, REDIRECT, 1, 1, 1, 0, 16'h0080, 16'd4);
    vecs[9]  = mk(0, 16'h0000, 0, 0, 0, RUN,      1, 0, 0, 0, 16'h0080, 16'd4);
    vecs[10] = mk(0, 16'hBEEF, 0, 0, 1, RUN,      1, 0, 0, 0, 16'h0080, 16'd4);
    vecs[11] = mk(1, 16'h1234, 1, 0, 0, REDIRECT, 1, 1, 1, 0, 16'h1234, 16'd4);
    vecs[12] = mk(1, 16'h5555, 1, 1, 0, RUN,      1, 0, 0, 0, 16'h1234, 16'd4);
    vecs[13] = mk(0, 16'h0000, 1, 0, 0, HALTED,   0, 0, 0, 1, 16'h1234, 16'd4);
    vecs[14] = mk(0, 16'h0000, 0, 1, 0, HALTED,   0, 0, 0, 1, 16'h1234, 16'd5);
    vecs[15] = mk(0, 16'h0000, 1, 0, 0, HALTED,   0, 0, 0, 1, 16'h1234, 16'd6);
    vecs[16] = mk(0, 16'h0000, 0, 0, 1, RUN,      1, 0, 0, 0, 16'h1234, 16'd7);

    rst = 1'b0;
    applyStimulus(0, 16'h0000, 0, 0, 0);
    #7;
    $display("[TB] reset and boot");
    checkOutput("reset", BOOT, 0, 0, 0, 1, 16'h0000, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("boot1", BOOT, 0, 0, 0, 1, 16'h0000, 16'd0);
    @(posedge clk); #1;
    checkOutput("boot2", RUN, 1, 0, 0, 0, 16'h0000, 16'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 17; i++) begin
      stepCycle(vecs[i].bt, vecs[i].tgt, vecs[i].halt, vecs[i].luh, vecs[i].res);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].pe, vecs[i].bs, vecs[i].fl,
                  vecs[i].nop, vecs[i].jmp, vecs[i].sc);
    end

    $display("[TB] reset during redirect");
    stepCycle(1, 16'h1234, 0, 0, 0);
    checkOutput("redir", REDIRECT, 1, 1, 1, 0, 16'h1234, 16'd7);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset", BOOT, 0, 0, 0, 1, 16'h0000, 16'd0);
    @(negedge clk);
    applyStimulus(1, 16'hAAAA, 1, 1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reboot1", BOOT, 0, 0, 0, 1, 16'h0000, 16'd0);
    @(posedge clk); #1;
    checkOutput("reboot2", RUN, 1, 0, 0, 0, 16'h0000, 16'd0);

    $display("[TB] halt for ten cycles then resume");
    stepCycle(0, 16'h0000, 1, 0, 0);
    checkOutput("halt0", HALTED, 0, 0, 0, 1, 16'h0000, 16'd0);
    for (int i = 1; i <= 10; i++) begin
      stepCycle(0, 16'h0000, 0, 0, 0);
      checkOutput($sformatf("halt%0d", i), HALTED, 0, 0, 0, 1, 16'h0000, 16'(i));
    end
    stepCycle(0, 16'h0000, 0, 0, 1);
    checkOutput("resume", RUN, 1, 0, 0, 0, 16'h0000, 16'd11);

    $display("[TB] stall counter saturation");
    @(negedge clk);
    applyStimulus(0, 16'h0000, 0, 1, 0);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("sat0", STALL, 0, 0, 0, 0, 16'h0000, STALL_CNT_MAX);
    stepCycle(0, 16'h0000, 0, 1, 0);
    checkOutput("sat1", STALL, 0, 0, 0, 0, 16'h0000, STALL_CNT_MAX);
    stepCycle(0, 16'h0000, 0, 0, 0);
    checkOutput("sat_run", RUN, 1, 0, 0, 0, 16'h0000, STALL_CNT_MAX);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
